// File: rtl/buzzer_sched.sv
// Fixed-priority sharing of one tone generator between reverse beep, horn and alarm,
// with per-source tone sequencing (steady, on/off, two-tone). All outputs registered.
module buzzer_sched #(
    parameter int unsigned TICK_DIV         = 1000000,
    parameter logic [21:0] HORN_DIV         = 22'd113635,
    parameter logic [21:0] BEEP_DIV         = 22'd49999,
    parameter logic [21:0] ALARM_HI_DIV     = 22'd56817,
    parameter logic [21:0] ALARM_LO_DIV     = 22'd113635,
    parameter logic [7:0]  BEEP_ON_TICKS    = 8'd30,
    parameter logic [7:0]  BEEP_OFF_TICKS   = 8'd30,
    parameter logic [7:0]  ALARM_STEP_TICKS = 8'd25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    output logic [2:0]  grant,
    output logic [21:0] note_div,
    output logic        mute,
    output logic        active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HORN,
        S_BEEP_ON,
        S_BEEP_OFF,
        S_ALARM_HI,
        S_ALARM_LO
    } state_t;

    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [23:0] tick_q, tick_d;
    logic [7:0]  phase_q, phase_d;
    logic [2:0]  win;
    logic [7:0]  phase_len;
    logic        tick;
    logic [21:0] div_d;
    logic        mute_d;

    always_comb begin
        if (req[2])      win = 3'b100;
        else if (req[1]) win = 3'b010;
        else if (req[0]) win = 3'b001;
        else             win = 3'b000;
    end

    always_comb begin
        case (state_q)
            S_BEEP_ON:              phase_len = BEEP_ON_TICKS;
            S_BEEP_OFF:             phase_len = BEEP_OFF_TICKS;
            S_ALARM_HI, S_ALARM_LO: phase_len = ALARM_STEP_TICKS;
            default:                phase_len = 8'd0;
        endcase
    end

    assign tick = (tick_q == TICK_LAST);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        if (win != grant) begin
            // New owner (or release to idle): the pattern always starts from its first phase.
            tick_d  = '0;
            phase_d = '0;
            case (win)
                3'b100:  state_d = S_ALARM_HI;
                3'b010:  state_d = S_HORN;
                3'b001:  state_d = S_BEEP_ON;
                default: state_d = S_IDLE;
            endcase
        end else if (phase_len != 8'd0) begin
            tick_d = tick ? '0 : tick_q + 24'd1;
            if (tick) begin
                if (phase_q == phase_len - 8'd1) begin
                    phase_d = '0;
                    case (state_q)
                        S_BEEP_ON:  state_d = S_BEEP_OFF;
                        S_BEEP_OFF: state_d = S_BEEP_ON;
                        S_ALARM_HI: state_d = S_ALARM_LO;
                        S_ALARM_LO: state_d = S_ALARM_HI;
                        default:    state_d = state_q;
                    endcase
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        div_d  = '0;
        mute_d = 1'b1;
        case (state_d)
            S_HORN:     begin div_d = HORN_DIV;     mute_d = 1'b0; end
            S_BEEP_ON:  begin div_d = BEEP_DIV;     mute_d = 1'b0; end
            S_ALARM_HI: begin div_d = ALARM_HI_DIV; mute_d = 1'b0; end
            S_ALARM_LO: begin div_d = ALARM_LO_DIV; mute_d = 1'b0; end
            default:    begin div_d = '0;           mute_d = 1'b1; end
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            phase_q  <= '0;
            grant    <= '0;
            note_div <= '0;
            mute     <= 1'b1;
            active   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            phase_q  <= phase_d;
            grant    <= win;
            note_div <= div_d;
            mute     <= mute_d;
            active   <= |win;
        end
    end

endmodule

// File: tb/tb_buzzer_sched.sv
// Self-checking bench for buzzer_sched: directed test-plan steps followed by random
// request traffic, all compared against an elapsed-time reference model.
module tb_buzzer_sched;

    localparam int TD    = 10;
    localparam int ON_T  = 3;
    localparam int OFF_T = 3;
    localparam int STP_T = 2;

    localparam int HORN_D = 113635;
    localparam int BEEP_D = 49999;
    localparam int AHI_D  = 56817;
    localparam int ALO_D  = 113635;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  grant;
    logic [21:0] note_div;
    logic        mute;
    logic        active;

    int n_checks;
    int n_errors;

    // Reference model: current owner and the clock edge at which it took over.
    int        edge_n;
    logic [2:0] m_owner;
    int        m_start;

    buzzer_sched #(
        .TICK_DIV        (TD),
        .HORN_DIV        (22'd113635),
        .BEEP_DIV        (22'd49999),
        .ALARM_HI_DIV    (22'd56817),
        .ALARM_LO_DIV    (22'd113635),
        .BEEP_ON_TICKS   (8'(ON_T)),
        .BEEP_OFF_TICKS  (8'(OFF_T)),
        .ALARM_STEP_TICKS(8'(STP_T))
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .note_div(note_div),
        .mute    (mute),
        .active  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] winner(input logic [2:0] r);
        if (r[2])      return 3'b100;
        else if (r[1]) return 3'b010;
        else if (r[0]) return 3'b001;
        return 3'b000;
    endfunction

    task automatic check_model(input string tag);
        int el;
        int exp_div;
        int exp_mute;
        el = edge_n - m_start;
        exp_div  = 0;
        exp_mute = 1;
        case (m_owner)
            3'b010: begin exp_div = HORN_D; exp_mute = 0; end
            3'b001: begin
                if ((el % ((ON_T + OFF_T) * TD)) < ON_T * TD) begin
                    exp_div = BEEP_D; exp_mute = 0;
                end
            end
            3'b100: begin
                exp_mute = 0;
                exp_div  = ((el % (2 * STP_T * TD)) < STP_T * TD) ? AHI_D : ALO_D;
            end
            default: ;
        endcase
        check({tag, ".grant"},    32'(grant),    32'(m_owner));
        check({tag, ".note_div"}, 32'(note_div), 32'(exp_div));
        check({tag, ".mute"},     32'(mute),     32'(exp_mute));
        check({tag, ".active"},   32'(active),   32'(m_owner != 3'b000));
    endtask

    // Apply r for n clock edges, checking every cycle just after the edge.
    task automatic step(input logic [2:0] r, input int n, input string tag);
        logic [2:0] w;
        for (int i = 0; i < n; i++) begin
            req = r;
            @(posedge clk);
            edge_n++;
            w = winner(r);
            if (w != m_owner) begin
                m_owner = w;
                m_start = edge_n;
            end
            #1;
            check_model(tag);
        end
    endtask

    initial begin
        logic [2:0] r;
        int         len;
        n_checks = 0;
        n_errors = 0;
        edge_n   = 0;
        m_owner  = 3'b000;
        m_start  = 0;
        req      = 3'b000;
        rst_n    = 1'b0;

        #12;
        check("reset.grant",    32'(grant),    32'd0);
        check("reset.note_div", 32'(note_div), 32'd0);
        check("reset.mute",     32'(mute),     32'd1);
        check("reset.active",   32'(active),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Beep: on for 30 cycles, off for 30, on again.
        step(3'b001, 1, "beep_first");
        check("beep_first_div", 32'(note_div), 32'd49999);
        step(3'b001, 30, "beep_on");
        check("beep_off_mute", 32'(mute), 32'd1);
        step(3'b001, 30, "beep_off");
        check("beep_on2_mute", 32'(mute), 32'd0);
        step(3'b001, 10, "beep_run");
        step(3'b000, 3, "idle");

        // Horn steady for 500 cycles.
        step(3'b010, 500, "horn");
        step(3'b000, 2, "idle");

        // Alarm two-tone.
        step(3'b100, 1, "alarm_first");
        check("alarm_first_div", 32'(note_div), 32'd56817);
        step(3'b100, 90, "alarm");
        step(3'b000, 2, "idle");

        // Beep in its off phase, preempted by alarm, then resumes with a fresh on phase.
        step(3'b001, 40, "beep_to_off");
        step(3'b101, 1, "preempt");
        check("preempt_grant", 32'(grant), 32'b100);
        step(3'b101, 6, "preempt_hold");
        step(3'b001, 1, "resume");
        check("resume_div", 32'(note_div), 32'd49999);
        step(3'b001, 35, "resume_run");

        // Horn handing directly to beep with no idle gap.
        step(3'b010, 5, "handoff_horn");
        step(3'b001, 1, "handoff");
        check("handoff_grant", 32'(grant), 32'b001);
        step(3'b001, 5, "handoff_run");
        step(3'b000, 2, "idle");

        // Reset in the middle of ALARM_LO.
        step(3'b100, 25, "alarm_lo");
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.grant",    32'(grant),    32'd0);
        check("rst_mid.note_div", 32'(note_div), 32'd0);
        check("rst_mid.mute",     32'(mute),     32'd1);
        check("rst_mid.active",   32'(active),   32'd0);
        m_owner = 3'b000;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        step(3'b100, 1, "after_rst");
        check("after_rst_div", 32'(note_div), 32'd56817);
        step(3'b100, 30, "after_rst_run");

        // Single-cycle glitch.
        step(3'b000, 2, "idle");
        step(3'b010, 1, "glitch");
        step(3'b000, 2, "glitch_rel");

        // Random request traffic, including short glitches and long holds.
        for (int k = 0; k < 60; k++) begin
            r   = 3'($urandom_range(0, 7));
            len = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 80));
            step(r, len, "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
